// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage and its CP0 block.
package wb_stage_pkg;

  localparam int          MS_TO_WS_BUS_WD = 124;
  localparam int          WS_TO_RF_BUS_WD = 38;
  localparam logic [31:0] EX_ENTRY        = 32'hBFC0_0380;
  localparam int          COUNT_DIV       = 2;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic        tlbp;
    logic        tlbr;
    logic        tlbwi;
    logic        tlbwr;
    logic [31:0] badvaddr;
    logic [4:0]  mfc0_rd;
    logic        ex;
    logic [4:0]  exc_code;
    logic        bd;
    logic        eret;
    logic [2:0]  sel;
    logic        mtc0;
    logic        mfc0;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake: valid/bus forward, allowin back.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       ws_allowin;

  modport master (output ms_to_ws_valid, ms_to_ws_bus, input ws_allowin);
  modport slave  (input ms_to_ws_valid, ms_to_ws_bus, output ws_allowin);

endinterface

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC and read mux.
// Timer interrupt (Cause.TI / IP[7]) exists only when WB_TIMER_INT_EN is defined.
module wb_stage_cp0_regs #(
  parameter int COUNT_DIV = wb_stage_pkg::COUNT_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ext_int_in,
  input  logic        ex_we,
  input  logic [4:0]  ex_code,
  input  logic        ex_bd,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_badvaddr,
  input  logic        eret_we,
  input  logic        mtc0_we,
  input  logic [4:0]  addr,
  input  logic [2:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        int_pend
);
  import wb_stage_pkg::*;

  localparam int              DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(COUNT_DIV - 1);

  logic [31:0]      badvaddr_q, count_q, compare_q, epc_q;
  logic [7:0]       status_im;
  logic             status_exl, status_ie;
  logic             cause_bd;
  logic [5:0]       cause_ip_hw;
  logic [1:0]       cause_ip_sw;
  logic [4:0]       cause_exc;
  logic [DIV_W-1:0] div_q;
  logic             ti;
  logic             sel0, count_tick;
  logic             wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0]      count_next, compare_next;
  logic [31:0]      status_rd, cause_rd;
  logic             ext_int_unused;

  assign ext_int_unused = ext_int_in[5];

  assign sel0       = (sel == 3'd0);
  assign wr_count   = mtc0_we && sel0 && (addr == CP0_COUNT);
  assign wr_compare = mtc0_we && sel0 && (addr == CP0_COMPARE);
  assign wr_status  = mtc0_we && sel0 && (addr == CP0_STATUS);
  assign wr_cause   = mtc0_we && sel0 && (addr == CP0_CAUSE);
  assign wr_epc     = mtc0_we && sel0 && (addr == CP0_EPC);

  // Divider counts down; Count steps on terminal count, a Count write restarts the phase.
  assign count_tick = (div_q == '0);

  always_comb begin
    count_next = count_q;
    if (wr_count)        count_next = wdata;
    else if (count_tick) count_next = count_q + 32'd1;
  end

  assign compare_next = wr_compare ? wdata : compare_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      div_q     <= DIV_LOAD;
      compare_q <= '0;
    end else begin
      count_q <= count_next;
      div_q   <= (wr_count || count_tick) ? DIV_LOAD : div_q - DIV_W'(1);
      if (wr_compare) compare_q <= wdata;
    end
  end

`ifdef WB_TIMER_INT_EN
  logic ti_q;

  // Compare against the post-update values so a match on a new Compare wins over its clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ti_q <= 1'b0;
    end else if ((count_tick || wr_count || wr_compare) && (count_next == compare_next)) begin
      ti_q <= 1'b1;
    end else if (wr_compare) begin
      ti_q <= 1'b0;
    end
  end

  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr_q  <= '0;
      epc_q       <= '0;
      status_im   <= '0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
    end else begin
      cause_ip_hw <= {ti, ext_int_in[4:0]};
      if (ex_we) begin
        status_exl <= 1'b1;
        cause_exc  <= ex_code;
        if (!status_exl) begin
          epc_q    <= ex_bd ? ex_pc - 32'd4 : ex_pc;
          cause_bd <= ex_bd;
        end
        if (is_addr_exc(ex_code)) badvaddr_q <= ex_badvaddr;
      end else if (eret_we) begin
        status_exl <= 1'b0;
      end else if (mtc0_we) begin
        if (wr_status) begin
          status_im  <= wdata[15:8];
          status_exl <= wdata[1];
          status_ie  <= wdata[0];
        end
        if (wr_cause) cause_ip_sw <= wdata[9:8];
        if (wr_epc)   epc_q       <= wdata;
      end
    end
  end

  assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_rd  = {cause_bd, ti, 14'd0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b00};

  assign int_pend = status_ie && !status_exl && |({cause_ip_hw, cause_ip_sw} & status_im);
  assign epc      = epc_q;

  always_comb begin
    rdata = '0;
    if (sel0) begin
      case (addr)
        CP0_BADVADDR: rdata = badvaddr_q;
        CP0_COUNT:    rdata = count_q;
        CP0_COMPARE:  rdata = compare_q;
        CP0_STATUS:   rdata = status_rd;
        CP0_CAUSE:    rdata = cause_rd;
        CP0_EPC:      rdata = epc_q;
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: pipeline register, RF commit, debug trace, exception/eret flush.
// Optional timer interrupt in the CP0 block is enabled by WB_TIMER_INT_EN.
module wb_stage #(
  parameter logic [31:0] EX_ENTRY  = wb_stage_pkg::EX_ENTRY,
  parameter int          COUNT_DIV = wb_stage_pkg::COUNT_DIV
) (
  input  logic                                    clk,
  input  logic                                    reset,
  wb_stage_if.slave                               ms_ws,
  input  logic [5:0]                              ext_int_in,
  output logic [wb_stage_pkg::WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  output logic [4:0]                              WB_dest,
  output logic [31:0]                             WB_result,
  output logic                                    ws_inst_mfc0,
  output logic                                    flush,
  output logic [31:0]                             flush_pc,
  output logic [31:0]                             debug_wb_pc,
  output logic [3:0]                              debug_wb_rf_wen,
  output logic [4:0]                              debug_wb_rf_wnum,
  output logic [31:0]                             debug_wb_rf_wdata
);
  import wb_stage_pkg::*;

  logic        ws_valid, ws_ready_go;
  ms_to_ws_t   ws_bus;
  logic        int_pend, take_ex, eret_go, mtc0_go, rf_we;
  logic [4:0]  ex_code;
  logic [31:0] cp0_rdata, epc, rf_wdata;
  logic        tlb_unused;

  assign ws_ready_go     = 1'b1;
  assign ms_ws.ws_allowin = !ws_valid || ws_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid <= 1'b0;
    end else if (ms_ws.ws_allowin) begin
      ws_valid <= ms_ws.ms_to_ws_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_bus <= '0;
    end else if (ms_ws.ms_to_ws_valid && ms_ws.ws_allowin) begin
      ws_bus <= ms_to_ws_t'(ms_ws.ms_to_ws_bus);
    end
  end

  // TLB request bits ride along for a future TLB unit.
  assign tlb_unused = ^{ws_bus.tlbp, ws_bus.tlbr, ws_bus.tlbwi, ws_bus.tlbwr};

  // A pending interrupt turns the WB instruction into an exception; its own ex code wins.
  assign take_ex = ws_valid && (ws_bus.ex || int_pend);
  assign ex_code = ws_bus.ex ? ws_bus.exc_code : EXC_INT;
  assign eret_go = ws_valid && ws_bus.eret && !take_ex;
  assign mtc0_go = ws_valid && ws_bus.mtc0 && !take_ex;

  wb_stage_cp0_regs #(.COUNT_DIV(COUNT_DIV)) u_cp0 (
    .clk         (clk),
    .reset       (reset),
    .ext_int_in  (ext_int_in),
    .ex_we       (take_ex),
    .ex_code     (ex_code),
    .ex_bd       (ws_bus.bd),
    .ex_pc       (ws_bus.pc),
    .ex_badvaddr (ws_bus.badvaddr),
    .eret_we     (eret_go),
    .mtc0_we     (mtc0_go),
    .addr        (ws_bus.mfc0_rd),
    .sel         (ws_bus.sel),
    .wdata       (ws_bus.result),
    .rdata       (cp0_rdata),
    .epc         (epc),
    .int_pend    (int_pend)
  );

  assign rf_we    = ws_valid && ws_bus.gr_we && !take_ex;
  assign rf_wdata = ws_bus.mfc0 ? cp0_rdata : ws_bus.result;

  assign ws_to_rf_bus = {rf_we, ws_bus.dest, rf_wdata};
  assign WB_dest      = ws_valid ? ws_bus.dest : 5'd0;
  assign WB_result    = rf_wdata;
  assign ws_inst_mfc0 = ws_valid && ws_bus.mfc0;

  assign flush    = take_ex || eret_go;
  assign flush_pc = take_ex ? EX_ENTRY : epc;

  assign debug_wb_pc       = ws_bus.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_bus.dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; timer expectations follow WB_TIMER_INT_EN.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ext_int_in;
  logic [37:0] ws_to_rf_bus;
  logic [4:0]  WB_dest;
  logic [31:0] WB_result;
  logic        ws_inst_mfc0;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_pass  = 0;
  int n_total = 0;

  wb_stage_if ms_ws();

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_ws             (ms_ws),
    .ext_int_in        (ext_int_in),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .WB_dest           (WB_dest),
    .WB_result         (WB_result),
    .ws_inst_mfc0      (ws_inst_mfc0),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic ms_to_ws_t alu_inst(input logic [4:0] dest, input logic [31:0] res,
                                         input logic [31:0] pc);
    ms_to_ws_t b;
    b = '0;
    b.gr_we  = 1'b1;
    b.dest   = dest;
    b.result = res;
    b.pc     = pc;
    return b;
  endfunction

  function automatic ms_to_ws_t mfc0_inst(input logic [4:0] rd);
    ms_to_ws_t b;
    b = '0;
    b.mfc0    = 1'b1;
    b.gr_we   = 1'b1;
    b.dest    = 5'd2;
    b.mfc0_rd = rd;
    b.pc      = 32'hBFC0_1000;
    return b;
  endfunction

  function automatic ms_to_ws_t mtc0_inst(input logic [4:0] rd, input logic [31:0] val);
    ms_to_ws_t b;
    b = '0;
    b.mtc0    = 1'b1;
    b.mfc0_rd = rd;
    b.result  = val;
    b.pc      = 32'hBFC0_2000;
    return b;
  endfunction

  function automatic ms_to_ws_t exc_inst(input logic [4:0] code, input logic bd,
                                         input logic [31:0] pc, input logic [31:0] bva);
    ms_to_ws_t b;
    b = '0;
    b.ex       = 1'b1;
    b.exc_code = code;
    b.bd       = bd;
    b.pc       = pc;
    b.badvaddr = bva;
    b.gr_we    = 1'b1;
    b.dest     = 5'd3;
    b.result   = 32'h0000_DEAD;
    return b;
  endfunction

  task automatic send(input ms_to_ws_t b);
    @(negedge clk);
    ms_ws.ms_to_ws_valid = 1'b1;
    ms_ws.ms_to_ws_bus   = b;
    @(posedge clk);
    #1;
    ms_ws.ms_to_ws_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_cp0(input string tag, input logic [4:0] rd, input logic [31:0] exp);
    send(mfc0_inst(rd));
    check(tag, 64'(WB_result), 64'(exp));
  endtask

  initial begin
    ms_to_ws_t b;
    logic      saw_flush;
    logic      exp_timer;
`ifdef WB_TIMER_INT_EN
    exp_timer = 1'b1;
`else
    exp_timer = 1'b0;
`endif
    reset                = 1'b1;
    ext_int_in           = 6'd0;
    ms_ws.ms_to_ws_valid = 1'b0;
    ms_ws.ms_to_ws_bus   = '0;

    #12;
    check("reset_flush",     64'(flush),           64'd0);
    check("reset_rf_bus",    64'(ws_to_rf_bus),    64'd0);
    check("reset_wb_dest",   64'(WB_dest),         64'd0);
    check("reset_allowin",   64'(ms_ws.ws_allowin), 64'd1);
    check("reset_rf_wen",    64'(debug_wb_rf_wen), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    send(alu_inst(5'd5, 32'h0000_1234, 32'hBFC0_0010));
    check("addu_rf_bus",  64'(ws_to_rf_bus),      64'({1'b1, 5'd5, 32'h0000_1234}));
    check("addu_rf_wen",  64'(debug_wb_rf_wen),   64'h0F);
    check("addu_wnum",    64'(debug_wb_rf_wnum),  64'd5);
    check("addu_wdata",   64'(debug_wb_rf_wdata), 64'h1234);
    check("addu_pc",      64'(debug_wb_pc),       64'hBFC0_0010);
    check("addu_wb_dest", 64'(WB_dest),           64'd5);
    check("addu_flush",   64'(flush),             64'd0);
    idle(1);
    check("bubble_rf_wen",  64'(debug_wb_rf_wen), 64'd0);
    check("bubble_wb_dest", 64'(WB_dest),         64'd0);

    read_cp0("status_reset", CP0_STATUS, 32'h0040_0000);
    check("mfc0_flag", 64'(ws_inst_mfc0), 64'd1);
    read_cp0("compare_reset", CP0_COMPARE, 32'h0000_0000);

    send(exc_inst(EXC_SYS, 1'b1, 32'hBFC0_0104, 32'h0));
    check("sys_flush",    64'(flush),           64'd1);
    check("sys_flush_pc", 64'(flush_pc),        64'hBFC0_0380);
    check("sys_rf_wen",   64'(debug_wb_rf_wen), 64'd0);
    read_cp0("sys_epc",    CP0_EPC,    32'hBFC0_0100);
    read_cp0("sys_cause",  CP0_CAUSE,  32'h8000_0020);
    read_cp0("sys_status", CP0_STATUS, 32'h0040_0002);

    send(exc_inst(EXC_ADEL, 1'b0, 32'hBFC0_0200, 32'h8000_0003));
    check("adel_flush_pc", 64'(flush_pc), 64'hBFC0_0380);
    read_cp0("adel_badvaddr", CP0_BADVADDR, 32'h8000_0003);
    read_cp0("adel_cause",    CP0_CAUSE,    32'h8000_0010);
    read_cp0("adel_epc_held", CP0_EPC,      32'hBFC0_0100);

    send(mtc0_inst(CP0_EPC, 32'hBFC0_0200));
    check("mtc0_epc_flush", 64'(flush), 64'd0);
    b      = '0;
    b.eret = 1'b1;
    b.pc   = 32'hBFC0_0400;
    send(b);
    check("eret_flush",    64'(flush),    64'd1);
    check("eret_flush_pc", 64'(flush_pc), 64'hBFC0_0200);
    read_cp0("eret_status", CP0_STATUS, 32'h0040_0000);

    send(mtc0_inst(CP0_STATUS, 32'h0000_0401));
    read_cp0("int_status", CP0_STATUS, 32'h0040_0401);
    ext_int_in = 6'b000001;
    idle(2);
    check("int_no_valid_flush", 64'(flush), 64'd0);
    send(alu_inst(5'd7, 32'h0000_0077, 32'hBFC0_0300));
    check("int_flush",    64'(flush),           64'd1);
    check("int_flush_pc", 64'(flush_pc),        64'hBFC0_0380);
    check("int_rf_wen",   64'(debug_wb_rf_wen), 64'd0);
    read_cp0("int_epc_exl_masked", CP0_EPC, 32'hBFC0_0300);
    check("int_masked_flush", 64'(flush), 64'd0);
    ext_int_in = 6'd0;
    idle(2);
    read_cp0("int_cause", CP0_CAUSE, 32'h0000_0000);

    send(mtc0_inst(CP0_COMPARE, 32'd10));
    send(mtc0_inst(CP0_COUNT,   32'd0));
    send(mtc0_inst(CP0_STATUS,  32'h0000_8001));
    saw_flush = 1'b0;
    for (int i = 0; i < 40 && !saw_flush; i++) begin
      send('0);
      if (flush) begin
        saw_flush = 1'b1;
        check("timer_flush_pc", 64'(flush_pc), 64'hBFC0_0380);
      end
    end
    check("timer_flush_seen", 64'(saw_flush), 64'(exp_timer));
    read_cp0("timer_cause", CP0_CAUSE, exp_timer ? 32'h4000_8000 : 32'h0000_0000);

    send(mtc0_inst(CP0_COUNT, 32'd100));
    read_cp0("count_wr_0", CP0_COUNT, 32'd100);
    read_cp0("count_wr_1", CP0_COUNT, 32'd100);
    read_cp0("count_wr_2", CP0_COUNT, 32'd101);
    send(mtc0_inst(CP0_COUNT, 32'hFFFF_FFFF));
    read_cp0("count_wrap_0", CP0_COUNT, 32'hFFFF_FFFF);
    read_cp0("count_wrap_1", CP0_COUNT, 32'hFFFF_FFFF);
    read_cp0("count_wrap_2", CP0_COUNT, 32'h0000_0000);

    send(exc_inst(EXC_BP, 1'b0, 32'hBFC0_0500, 32'h0));
    check("pre_reset_flush", 64'(flush), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_flush",  64'(flush),           64'd0);
    check("async_reset_rf_bus", 64'(ws_to_rf_bus),    64'd0);
    @(negedge clk);
    reset = 1'b0;
    read_cp0("post_reset_status",  CP0_STATUS,  32'h0040_0000);
    read_cp0("post_reset_compare", CP0_COMPARE, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
